rc6_key_schedule: RTL and testbench

Generates the 44-word RC6-32/20/16 round-key table S[0..43] from a 128-bit user key and serves word pairs to the round datapath. It sits directly upstream of the RC6 round stage: that stage's rfunct consumes key1/key2 per round, and this block supplies them. It is iterative, with one key-mixing step per clock, and holds the table until the next load.

---
 rtl/rc6_pkg.sv | 20 ++
 rtl/rc6_key_schedule_if.sv | 23 ++
 rtl/rc6_key_schedule.sv | 168 ++++++++++++++++
 tb/tb_rc6_key_schedule.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc6_pkg.sv
// Constants, state type and rotate helper shared by the RC6 key schedule
// and the round datapath.
package rc6_pkg;

   localparam logic [31:0] P32 = 32'hB7E15163;
   localparam logic [31:0] Q32 = 32'h9E3779B9;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      MIX,
      DONE
   } ks_state_e;

   // A rotation amount of zero must return the data unchanged; data >> 32 is 0 here.
   function automatic logic [31:0] rotl32(input logic [31:0] data, input logic [4:0] amt);
      return (data << amt) | (data >> (6'd32 - {1'b0, amt}));
   endfunction

endpackage

// File: rtl/rc6_key_schedule_if.sv
// Key-load handshake and round-key read bus between the key schedule
// (slave) and its controller / round datapath (master).
interface rc6_key_schedule_if #(
   parameter int KEYW = 4
);
   logic [32*KEYW-1:0] key_in;
   logic               key_load;
   logic               busy;
   logic               key_ready;
   logic [4:0]         rd_idx;
   logic [31:0]        rd_key1;
   logic [31:0]        rd_key2;

   modport master (
      output key_in, key_load, rd_idx,
      input  busy, key_ready, rd_key1, rd_key2
   );

   modport slave (
      input  key_in, key_load, rd_idx,
      output busy, key_ready, rd_key1, rd_key2
   );
endinterface

// File: rtl/rc6_key_schedule.sv
// Iterative RC6 key schedule: fills S[] with the magic-constant sequence,
// then runs one key-mixing step per clock and serves S word pairs.
module rc6_key_schedule
   import rc6_pkg::*;
#(
   parameter int ROUNDS = 20,
   parameter int KEYW   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   rc6_key_schedule_if.slave    ks
);

   localparam int T    = 2*ROUNDS + 4;
   localparam int NMIX = 3*((T > KEYW) ? T : KEYW);
   localparam int IW   = $clog2(T);
   localparam int JW   = (KEYW > 1) ? $clog2(KEYW) : 1;
   localparam int NW   = $clog2(NMIX);

   localparam logic [IW-1:0] I_LAST = IW'(T - 1);
   localparam logic [JW-1:0] J_LAST = JW'(KEYW - 1);
   localparam logic [NW-1:0] N_LAST = NW'(NMIX - 1);
   localparam logic [5:0]    HALF_T = 6'(T / 2);

   ks_state_e     state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic [NW-1:0] n_q, n_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [31:0]   sacc_q, sacc_d;
   logic [31:0]   l_q [KEYW];
   logic [31:0]   l_d [KEYW];
   logic          busy_q, busy_d;
   logic          key_ready_q, key_ready_d;
   logic [31:0]   rd_key1_q, rd_key1_d;
   logic [31:0]   rd_key2_q, rd_key2_d;

   logic [31:0]   s_mem [T];
   logic          s_we;
   logic [IW-1:0] s_waddr;
   logic [31:0]   s_wdata;

   logic [31:0]   key_words [KEYW];
   logic [31:0]   a_mix, ab_sum, b_mix;
   logic [IW-1:0] rd_addr0, rd_addr1;
   logic          rd_ok;

   generate
      for (genvar gi = 0; gi < KEYW; gi++) begin : g_key_words
         assign key_words[gi] = ks.key_in[32*gi +: 32];
      end
   endgenerate

   // One mixing step: the new A feeds both the S write-back and the B update.
   assign a_mix  = rotl32(s_mem[i_q] + a_q + b_q, 5'd3);
   assign ab_sum = a_mix + b_q;
   assign b_mix  = rotl32(l_q[j_q] + ab_sum, ab_sum[4:0]);

   assign rd_addr0 = IW'({ks.rd_idx, 1'b0});
   assign rd_addr1 = IW'({ks.rd_idx, 1'b1});
   assign rd_ok    = key_ready_q && ({1'b0, ks.rd_idx} < HALF_T);

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      n_d     = n_q;
      a_d     = a_q;
      b_d     = b_q;
      sacc_d  = sacc_q;
      l_d     = l_q;
      s_we    = 1'b0;
      s_waddr = i_q;
      s_wdata = sacc_q;

      case (state_q)
         IDLE, DONE: begin
            if (ks.key_load) begin
               for (int k = 0; k < KEYW; k++) begin
                  l_d[k] = key_words[k];
               end
               i_d     = '0;
               j_d     = '0;
               n_d     = '0;
               a_d     = '0;
               b_d     = '0;
               sacc_d  = P32;
               state_d = INIT;
            end
         end
         INIT: begin
            s_we   = 1'b1;
            sacc_d = sacc_q + Q32;
            if (i_q == I_LAST) begin
               i_d     = '0;
               state_d = MIX;
            end else begin
               i_d = i_q + IW'(1);
            end
         end
         MIX: begin
            s_we       = 1'b1;
            s_wdata    = a_mix;
            a_d        = a_mix;
            b_d        = b_mix;
            l_d[j_q]   = b_mix;
            i_d        = (i_q == I_LAST) ? '0 : i_q + IW'(1);
            j_d        = (j_q == J_LAST) ? '0 : j_q + JW'(1);
            n_d        = n_q + NW'(1);
            if (n_q == N_LAST) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d      = (state_d == INIT) || (state_d == MIX);
      key_ready_d = (state_d == DONE);
      rd_key1_d   = rd_ok ? s_mem[rd_addr0] : '0;
      rd_key2_d   = rd_ok ? s_mem[rd_addr1] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         i_q         <= '0;
         j_q         <= '0;
         n_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sacc_q      <= '0;
         for (int k = 0; k < KEYW; k++) begin
            l_q[k] <= '0;
         end
         busy_q      <= 1'b0;
         key_ready_q <= 1'b0;
         rd_key1_q   <= '0;
         rd_key2_q   <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         n_q         <= n_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sacc_q      <= sacc_d;
         l_q         <= l_d;
         busy_q      <= busy_d;
         key_ready_q <= key_ready_d;
         rd_key1_q   <= rd_key1_d;
         rd_key2_q   <= rd_key2_d;
      end
   end

   // Table contents survive reset; they are only meaningful once key_ready is up.
   always_ff @(posedge clk) begin
      if (s_we) begin
         s_mem[s_waddr] <= s_wdata;
      end
   end

   assign ks.busy      = busy_q;
   assign ks.key_ready = key_ready_q;
   assign ks.rd_key1   = rd_key1_q;
   assign ks.rd_key2   = rd_key2_q;

endmodule

// File: tb/tb_rc6_key_schedule.sv
// Self-checking bench for rc6_key_schedule: a timeline/table reference model
// with a per-cycle compare process, plus RC6 encryption of the zero-key vector.
module tb_rc6_key_schedule;

   typedef logic [31:0] tab_t [44];

   logic clk = 1'b0;
   logic rst = 1'b1;

   rc6_key_schedule_if #(.KEYW(4)) ks_if ();

   rc6_key_schedule #(.ROUNDS(20), .KEYW(4)) dut (
      .clk   (clk),
      .reset (rst),
      .ks    (ks_if.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic cmp_en = 1'b0;

   function automatic logic [31:0] m_rotl(logic [31:0] x, int r);
      int rr;
      rr = r & 31;
      if (rr == 0) return x;
      return (x << rr) | (x >> (32 - rr));
   endfunction

   function automatic tab_t model_schedule(logic [127:0] key);
      tab_t s;
      logic [31:0] l [4];
      logic [31:0] a, b;
      int i, j;
      for (int k = 0; k < 4; k++) l[k] = key[32*k +: 32];
      s[0] = 32'hB7E15163;
      for (int k = 1; k < 44; k++) s[k] = s[k-1] + 32'h9E3779B9;
      a = 0; b = 0; i = 0; j = 0;
      for (int n = 0; n < 132; n++) begin
         a = m_rotl(s[i] + a + b, 3);
         s[i] = a;
         b = m_rotl(l[j] + a + b, int'((a + b) & 32'd31));
         l[j] = b;
         i = (i + 1) % 44;
         j = (j + 1) % 4;
      end
      return s;
   endfunction

   // RC6-32/20 encryption; result packs {D,C,B,A} with A in bits 31:0.
   function automatic logic [127:0] model_encrypt(tab_t s, logic [127:0] pt);
      logic [31:0] a, b, c, d, t, u, tmp;
      a = pt[31:0]; b = pt[63:32]; c = pt[95:64]; d = pt[127:96];
      b = b + s[0];
      d = d + s[1];
      for (int r = 1; r <= 20; r++) begin
         tmp = b * ((b << 1) + 32'd1);
         t   = m_rotl(tmp, 5);
         tmp = d * ((d << 1) + 32'd1);
         u   = m_rotl(tmp, 5);
         a   = m_rotl(a ^ t, int'(u[4:0])) + s[2*r];
         c   = m_rotl(c ^ u, int'(t[4:0])) + s[2*r+1];
         tmp = a; a = b; b = c; c = d; d = tmp;
      end
      a = a + s[42];
      c = c + s[43];
      return {d, c, b, a};
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Reference timeline: what busy/key_ready/read outputs must be after each edge.
   logic        m_busy  = 1'b0;
   logic        m_ready = 1'b0;
   int          m_cnt   = 0;
   tab_t        m_tab, m_pend;
   logic [31:0] exp_k1 = 0, exp_k2 = 0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_busy = 1'b0; m_ready = 1'b0; exp_k1 = 0; exp_k2 = 0;
         end else begin
            int idx;
            idx = int'(ks_if.rd_idx);
            if (m_ready && idx < 22) begin
               exp_k1 = m_tab[2*idx];
               exp_k2 = m_tab[2*idx+1];
            end else begin
               exp_k1 = 0;
               exp_k2 = 0;
            end
            if (!m_busy && ks_if.key_load) begin
               m_pend  = model_schedule(ks_if.key_in);
               m_busy  = 1'b1;
               m_ready = 1'b0;
               m_cnt   = 0;
            end else if (m_busy) begin
               m_cnt++;
               if (m_cnt == 176) begin
                  m_busy  = 1'b0;
                  m_ready = 1'b1;
                  m_tab   = m_pend;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check32("busy",      {31'b0, ks_if.busy},      {31'b0, m_busy});
            check32("key_ready", {31'b0, ks_if.key_ready}, {31'b0, m_ready});
            check32("rd_key1",   ks_if.rd_key1, exp_k1);
            check32("rd_key2",   ks_if.rd_key2, exp_k2);
         end
      end
   end

   task automatic do_load(input logic [127:0] key, input int ignore_at,
                          output int lat, output logic ready_e0);
      ks_if.key_in   = key;
      ks_if.key_load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ks_if.key_load = 1'b0;
      ready_e0 = ks_if.key_ready;
      lat = -1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (ks_if.key_ready) begin
            lat = cyc;
            break;
         end
         ks_if.key_load = (cyc == ignore_at);
         ks_if.key_in   = {$urandom, $urandom, $urandom, $urandom};
         ks_if.rd_idx   = 5'($urandom_range(0, 31));
         @(negedge clk);
      end
      ks_if.key_load = 1'b0;
   endtask

   task automatic sweep(output tab_t t);
      for (int k = 0; k < 32; k++) begin
         ks_if.rd_idx = 5'(k);
         @(negedge clk);
         if (k < 22) begin
            t[2*k]   = ks_if.rd_key1;
            t[2*k+1] = ks_if.rd_key2;
         end
      end
   endtask

   initial begin
      tab_t        zt, dt;
      logic [127:0] ct, vec;
      int          lat;
      logic        r0;

      vec = 128'h1EA44898_4EDF29C1_78F7B156_36A5C38F;
      ks_if.key_in   = '0;
      ks_if.key_load = 1'b0;
      ks_if.rd_idx   = '0;
      repeat (3) @(negedge clk);

      check32("reset_busy",  {31'b0, ks_if.busy},      32'd0);
      check32("reset_ready", {31'b0, ks_if.key_ready}, 32'd0);
      check32("reset_key1",  ks_if.rd_key1, 32'd0);
      check32("reset_key2",  ks_if.rd_key2, 32'd0);

      check32("pin_rotl3",  m_rotl(32'hB7E15163, 3),  32'hBF0A8B1D);
      check32("pin_rotl31", m_rotl(32'h80000001, 31), 32'hC0000000);
      check32("pin_rotl0",  m_rotl(32'h12345678, 0),  32'h12345678);
      zt = model_schedule(128'd0);
      ct = model_encrypt(zt, 128'd0);
      for (int w = 0; w < 4; w++) check32("pin_model_ct", ct[32*w +: 32], vec[32*w +: 32]);

      rst = 1'b0;
      cmp_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         ks_if.rd_idx = 5'($urandom_range(0, 31));
         @(negedge clk);
      end

      do_load(128'd0, -1, lat, r0);
      check32("zero_latency", 32'(lat), 32'd176);
      sweep(dt);
      check32("zero_s0",  dt[0],  zt[0]);
      check32("zero_s1",  dt[1],  zt[1]);
      check32("zero_s42", dt[42], zt[42]);
      check32("zero_s43", dt[43], zt[43]);
      ct = model_encrypt(dt, 128'd0);
      for (int w = 0; w < 4; w++) check32("e2e_ct", ct[32*w +: 32], vec[32*w +: 32]);

      do_load({$urandom, $urandom, $urandom, $urandom}, 50, lat, r0);
      check32("ignored_load_latency", 32'(lat), 32'd176);
      sweep(dt);

      do_load({$urandom, $urandom, $urandom, $urandom}, -1, lat, r0);
      check32("reload_ready_drop", {31'b0, r0}, 32'd0);
      check32("reload_latency", 32'(lat), 32'd176);
      sweep(dt);

      ks_if.key_in   = {$urandom, $urandom, $urandom, $urandom};
      ks_if.key_load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ks_if.key_load = 1'b0;
      repeat (100) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check32("midrst_busy",  {31'b0, ks_if.busy},      32'd0);
      check32("midrst_ready", {31'b0, ks_if.key_ready}, 32'd0);
      check32("midrst_key1",  ks_if.rd_key1, 32'd0);
      check32("midrst_key2",  ks_if.rd_key2, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      do_load({$urandom, $urandom, $urandom, $urandom}, -1, lat, r0);
      check32("post_reset_latency", 32'(lat), 32'd176);
      sweep(dt);

      for (int n = 0; n < 100; n++) begin
         do_load({$urandom, $urandom, $urandom, $urandom}, (n % 10 == 0) ? 50 : -1, lat, r0);
         check32("rand_latency", 32'(lat), 32'd176);
         sweep(dt);
      end

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
